zeroriscy_ppu_issue_ctrl: RTL and testbench

// - Issue/retire controller for posit (PPU) instructions, between the ID stage and the EX-stage PPU core.
// - Latches operands, operator and destination register when ID requests.
// - Drives a one-cycle start pulse into the PPU core and waits for its valid.
// - Captures the result, writes it back to the register file and signals EX-ready to ID.
// - Also provides a timeout and a flush/drain path.

---
 rtl/zeroriscy_ppu_issue_ctrl_pkg.sv | 15 +
 rtl/zeroriscy_ppu_issue_ctrl.sv | 94 +++++++++
 tb/tb_zeroriscy_ppu_issue_ctrl.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/zeroriscy_ppu_issue_ctrl_pkg.sv
// zeroriscy_ppu_issue_ctrl_pkg: PPU operator codes and issue-controller state encoding
package zeroriscy_ppu_issue_ctrl_pkg;
    localparam int PPU_OP_WIDTH = 4;
    localparam logic [PPU_OP_WIDTH-1:0] PPU_ADD = 4'd0;
    localparam logic [PPU_OP_WIDTH-1:0] PPU_SUB = 4'd1;
    localparam logic [PPU_OP_WIDTH-1:0] PPU_MUL = 4'd2;
    localparam logic [PPU_OP_WIDTH-1:0] PPU_DIV = 4'd3;
    typedef enum logic [2:0] {
        PPU_IDLE,
        PPU_ISSUE,
        PPU_BUSY,
        PPU_DONE,
        PPU_DRAIN
    } ppu_ctrl_state_e;
endpackage

// File: rtl/zeroriscy_ppu_issue_ctrl.sv
// zeroriscy_ppu_issue_ctrl: issues posit ops to the PPU core, waits for the result and retires it to the RF
module zeroriscy_ppu_issue_ctrl #(
    parameter int PPU_OP_WIDTH = zeroriscy_ppu_issue_ctrl_pkg::PPU_OP_WIDTH,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    ppu_req_i,
    input  logic [PPU_OP_WIDTH-1:0] ppu_op_i,
    input  logic [31:0]             ppu_opa_i,
    input  logic [31:0]             ppu_opb_i,
    input  logic [4:0]              ppu_rd_i,
    input  logic                    flush_i,
    output logic                    ppu_en_o,
    output logic [31:0]             ppu_operand_a_o,
    output logic [31:0]             ppu_operand_b_o,
    output logic [PPU_OP_WIDTH-1:0] ppu_operator_o,
    input  logic [31:0]             ppu_result_i,
    input  logic                    ppu_valid_i,
    output logic                    rf_we_o,
    output logic [4:0]              rf_waddr_o,
    output logic [31:0]             rf_wdata_o,
    output logic                    ready_o,
    output logic                    timeout_o
);
    import zeroriscy_ppu_issue_ctrl_pkg::*;

    localparam int CW = $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYCLES - 1);

    ppu_ctrl_state_e state;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_inc;
    logic [4:0] rd_q;
    logic [31:0] result_q;
    logic timeout_q;

    assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= PPU_IDLE;
            cnt <= '0;
            ppu_operator_o <= '0;
            ppu_operand_a_o <= '0;
            ppu_operand_b_o <= '0;
            rd_q <= '0;
            result_q <= '0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= 1'b0;
            case (state)
                PPU_IDLE: if (ppu_req_i && !flush_i) begin
                    ppu_operator_o <= ppu_op_i;
                    ppu_operand_a_o <= ppu_opa_i;
                    ppu_operand_b_o <= ppu_opb_i;
                    rd_q <= ppu_rd_i;
                    state <= PPU_ISSUE;
                end
                PPU_ISSUE: begin
                    cnt <= '0;
                    state <= flush_i ? PPU_DRAIN : PPU_BUSY;
                end
                // flush beats valid beats timeout; a flushed op without its valid still owes one from the core
                PPU_BUSY: begin
                    cnt <= cnt_inc;
                    if (flush_i) begin
                        state <= ppu_valid_i ? PPU_IDLE : PPU_DRAIN;
                    end else if (ppu_valid_i) begin
                        result_q <= ppu_result_i;
                        state <= PPU_DONE;
                    end else if (cnt == CNT_MAX) begin
                        result_q <= '0;
                        timeout_q <= 1'b1;
                        state <= PPU_DONE;
                    end
                end
                PPU_DONE: state <= PPU_IDLE;
                PPU_DRAIN: begin
                    cnt <= cnt_inc;
                    if (ppu_valid_i || cnt == CNT_MAX) state <= PPU_IDLE;
                end
                default: state <= PPU_IDLE;
            endcase
        end
    end

    assign ppu_en_o = state == PPU_ISSUE;
    assign rf_we_o = state == PPU_DONE && rd_q != 5'd0 && !flush_i;
    assign rf_waddr_o = rd_q;
    assign rf_wdata_o = result_q;
    assign ready_o = (state == PPU_IDLE && !ppu_req_i) || state == PPU_DONE;
    assign timeout_o = timeout_q;
endmodule

// File: tb/tb_zeroriscy_ppu_issue_ctrl.sv
// tb_zeroriscy_ppu_issue_ctrl: cycle-indexed scenarios checked against latency arithmetic and a PPU core model
module tb_zeroriscy_ppu_issue_ctrl;
    import zeroriscy_ppu_issue_ctrl_pkg::*;

    localparam int TO = 8;
    localparam int OPW = PPU_OP_WIDTH;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic ppu_req_i = 1'b0;
    logic [OPW-1:0] ppu_op_i = '0;
    logic [31:0] ppu_opa_i = '0;
    logic [31:0] ppu_opb_i = '0;
    logic [4:0] ppu_rd_i = '0;
    logic flush_i = 1'b0;
    logic ppu_en_o;
    logic [31:0] ppu_operand_a_o;
    logic [31:0] ppu_operand_b_o;
    logic [OPW-1:0] ppu_operator_o;
    logic [31:0] ppu_result_i = '0;
    logic ppu_valid_i = 1'b0;
    logic rf_we_o;
    logic [4:0] rf_waddr_o;
    logic [31:0] rf_wdata_o;
    logic ready_o;
    logic timeout_o;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    zeroriscy_ppu_issue_ctrl #(.PPU_OP_WIDTH(OPW), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .ppu_req_i(ppu_req_i),
        .ppu_op_i(ppu_op_i),
        .ppu_opa_i(ppu_opa_i),
        .ppu_opb_i(ppu_opb_i),
        .ppu_rd_i(ppu_rd_i),
        .flush_i(flush_i),
        .ppu_en_o(ppu_en_o),
        .ppu_operand_a_o(ppu_operand_a_o),
        .ppu_operand_b_o(ppu_operand_b_o),
        .ppu_operator_o(ppu_operator_o),
        .ppu_result_i(ppu_result_i),
        .ppu_valid_i(ppu_valid_i),
        .rf_we_o(rf_we_o),
        .rf_waddr_o(rf_waddr_o),
        .rf_wdata_o(rf_wdata_o),
        .ready_o(ready_o),
        .timeout_o(timeout_o)
    );

    task automatic test_reset();
        @(negedge clk);
        #1;
        nvec++;
        if ({ppu_en_o, rf_we_o, timeout_o, ready_o, ppu_operator_o, ppu_operand_a_o, ppu_operand_b_o, rf_waddr_o, rf_wdata_o}
            !== {1'b0, 1'b0, 1'b0, 1'b1, {OPW{1'b0}}, 64'h0, 5'h0, 32'h0})
        begin
            nerr++;
            $display("FAIL reset: en/we/to/rdy=%b%b%b%b wdata=%h got, want 0001 and zeros", ppu_en_o, rf_we_o, timeout_o, ready_o, rf_wdata_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One request held until retirement; core answers L cycles after the start pulse, or never when L exceeds TO
    task automatic test_op(input string name, input int lat, input logic [OPW-1:0] op,
                           input logic [31:0] a, input logic [31:0] b, input logic [31:0] res, input logic [4:0] rd);
        bit to;
        int done_c;
        int ens;
        to = !(lat >= 1 && lat <= TO);
        done_c = to ? 2 + TO : 2 + lat;
        ens = 0;
        for (int c = 0; c <= done_c + 1; c++) begin
            @(negedge clk);
            ppu_req_i = c <= done_c;
            ppu_op_i = op;
            ppu_opa_i = a;
            ppu_opb_i = b;
            ppu_rd_i = rd;
            ppu_valid_i = !to && c == 1 + lat;
            ppu_result_i = ppu_valid_i ? res : $urandom;
            #1;
            ens += int'(ppu_en_o);
            nvec++;
            if ({ppu_en_o, rf_we_o, ready_o, timeout_o} !== {c == 1, c == done_c && rd != 5'd0, c >= done_c, c == done_c && to}) begin
                nerr++;
                $display("FAIL %s cycle %0d: en/we/rdy/to=%b%b%b%b, want %b%b%b%b", name, c, ppu_en_o, rf_we_o, ready_o, timeout_o,
                         c == 1, c == done_c && rd != 5'd0, c >= done_c, c == done_c && to);
            end
            if (c >= 1) begin
                nvec++;
                if ({ppu_operator_o, ppu_operand_a_o, ppu_operand_b_o} !== {op, a, b}) begin
                    nerr++;
                    $display("FAIL %s operands cycle %0d: %h %h %h, want %h %h %h", name, c, ppu_operator_o, ppu_operand_a_o, ppu_operand_b_o, op, a, b);
                end
            end
            if (c == done_c) begin
                nvec++;
                if ({rf_waddr_o, rf_wdata_o} !== {rd, to ? 32'h0 : res}) begin
                    nerr++;
                    $display("FAIL %s writeback: addr=%0d data=%h, want addr=%0d data=%h", name, rf_waddr_o, rf_wdata_o, rd, to ? 32'h0 : res);
                end
            end
        end
        nvec++;
        if (ens != 1) begin
            nerr++;
            $display("FAIL %s start pulses: %0d seen, want 1", name, ens);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 24; i++)
            test_op("random", $urandom_range(1, TO + 3), OPW'($urandom), $urandom, $urandom, $urandom, 5'($urandom));
    endtask

    task automatic test_flush_busy();
        logic [31:0] res;
        res = $urandom;
        for (int c = 0; c <= 11; c++) begin
            @(negedge clk);
            ppu_req_i = c == 0 || (c >= 7 && c <= 10);
            ppu_op_i = c < 7 ? PPU_MUL : PPU_SUB;
            ppu_opa_i = c < 7 ? 32'h11111111 : 32'h22222222;
            ppu_opb_i = c < 7 ? 32'h33333333 : 32'h44444444;
            ppu_rd_i = c < 7 ? 5'd9 : 5'd12;
            flush_i = c == 2;
            ppu_valid_i = c == 6 || c == 9;
            ppu_result_i = c == 9 ? res : $urandom;
            #1;
            nvec++;
            if ({ppu_en_o, rf_we_o, ready_o, timeout_o} !== {c == 1 || c == 8, c == 10, c >= 10, 1'b0}) begin
                nerr++;
                $display("FAIL flush_busy cycle %0d: en/we/rdy/to=%b%b%b%b, want %b%b%b0", c, ppu_en_o, rf_we_o, ready_o, timeout_o,
                         c == 1 || c == 8, c == 10, c >= 10);
            end
            if (c == 8 || c == 10) begin
                nvec++;
                if ({ppu_operator_o, ppu_operand_a_o, ppu_operand_b_o, rf_waddr_o} !== {PPU_SUB, 32'h22222222, 32'h44444444, 5'd12}) begin
                    nerr++;
                    $display("FAIL flush_busy second op cycle %0d: %h %h %h rd=%0d, want second operands rd=12", c, ppu_operator_o, ppu_operand_a_o, ppu_operand_b_o, rf_waddr_o);
                end
            end
            if (c == 10) begin
                nvec++;
                if (rf_wdata_o !== res) begin
                    nerr++;
                    $display("FAIL flush_busy wdata: %h, want %h", rf_wdata_o, res);
                end
            end
        end
    endtask

    // Kill variants: in ISSUE (drain to timeout), in BUSY alongside valid, and in DONE
    task automatic test_flush_kinds();
        int flush_c[3] = '{1, 2, 3};
        int valid_c[3] = '{-1, 2, 2};
        int rdy_c[3] = '{10, 3, 3};
        for (int p = 0; p < 3; p++) begin
            for (int c = 0; c <= rdy_c[p] + 1; c++) begin
                @(negedge clk);
                ppu_req_i = c == 0;
                ppu_op_i = PPU_DIV;
                ppu_opa_i = $urandom;
                ppu_opb_i = $urandom;
                ppu_rd_i = 5'd17;
                flush_i = c == flush_c[p];
                ppu_valid_i = c == valid_c[p];
                ppu_result_i = $urandom;
                #1;
                nvec++;
                if ({ppu_en_o, rf_we_o, ready_o, timeout_o} !== {c == 1, 1'b0, c >= rdy_c[p], 1'b0}) begin
                    nerr++;
                    $display("FAIL flush_kind%0d cycle %0d: en/we/rdy/to=%b%b%b%b, want %b0%b0", p, c, ppu_en_o, rf_we_o, ready_o, timeout_o,
                             c == 1, c >= rdy_c[p]);
                end
            end
        end
        flush_i = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [31:0] res_a;
        logic [31:0] res_b;
        res_a = $urandom;
        res_b = $urandom;
        for (int c = 0; c <= 8; c++) begin
            @(negedge clk);
            ppu_req_i = c <= 7;
            ppu_op_i = c <= 3 ? PPU_ADD : PPU_MUL;
            ppu_opa_i = c <= 3 ? 32'hA0A0A0A0 : 32'hB1B1B1B1;
            ppu_opb_i = c <= 3 ? 32'hC2C2C2C2 : 32'hD3D3D3D3;
            ppu_rd_i = c <= 3 ? 5'd3 : 5'd4;
            ppu_valid_i = c == 2 || c == 6;
            ppu_result_i = c == 2 ? res_a : c == 6 ? res_b : $urandom;
            #1;
            nvec++;
            if ({ppu_en_o, rf_we_o, ready_o} !== {c == 1 || c == 5, c == 3 || c == 7, c == 3 || c == 7 || c == 8}) begin
                nerr++;
                $display("FAIL b2b cycle %0d: en/we/rdy=%b%b%b, want %b%b%b", c, ppu_en_o, rf_we_o, ready_o,
                         c == 1 || c == 5, c == 3 || c == 7, c == 3 || c == 7 || c == 8);
            end
            if (c >= 1) begin
                nvec++;
                if (ppu_operand_a_o !== (c <= 4 ? 32'hA0A0A0A0 : 32'hB1B1B1B1)) begin
                    nerr++;
                    $display("FAIL b2b operand_a cycle %0d: %h, want %h", c, ppu_operand_a_o, c <= 4 ? 32'hA0A0A0A0 : 32'hB1B1B1B1);
                end
            end
            if (c == 3 || c == 7) begin
                nvec++;
                if ({rf_waddr_o, rf_wdata_o} !== (c == 3 ? {5'd3, res_a} : {5'd4, res_b})) begin
                    nerr++;
                    $display("FAIL b2b write cycle %0d: addr=%0d data=%h", c, rf_waddr_o, rf_wdata_o);
                end
            end
        end
    endtask

    task automatic test_idle_valid();
        logic [31:0] prev;
        prev = rf_wdata_o;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            ppu_req_i = 1'b0;
            ppu_valid_i = 1'b1;
            ppu_result_i = $urandom;
            #1;
            nvec++;
            if ({ppu_en_o, rf_we_o, ready_o, timeout_o, rf_wdata_o} !== {4'b0010, prev}) begin
                nerr++;
                $display("FAIL idle_valid cycle %0d: en/we/rdy/to=%b%b%b%b wdata=%h, want 0010 %h", c, ppu_en_o, rf_we_o, ready_o, timeout_o, rf_wdata_o, prev);
            end
        end
        ppu_valid_i = 1'b0;
    endtask

    task automatic test_reset_busy();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            ppu_req_i = c == 0;
            ppu_op_i = PPU_SUB;
            ppu_opa_i = 32'h12345678;
            ppu_opb_i = 32'h9ABCDEF0;
            ppu_rd_i = 5'd7;
            ppu_valid_i = 1'b0;
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        nvec++;
        if ({ppu_en_o, rf_we_o, timeout_o, ready_o, ppu_operator_o, ppu_operand_a_o, ppu_operand_b_o, rf_waddr_o, rf_wdata_o}
            !== {1'b0, 1'b0, 1'b0, 1'b1, {OPW{1'b0}}, 64'h0, 5'h0, 32'h0})
        begin
            nerr++;
            $display("FAIL reset_busy: en/we/to/rdy=%b%b%b%b opa=%h rd=%0d, want 0001 and zeros", ppu_en_o, rf_we_o, timeout_o, ready_o, ppu_operand_a_o, rf_waddr_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            ppu_valid_i = c == 0;
            ppu_result_i = 32'hDEADBEEF;
            #1;
            nvec++;
            if ({ppu_en_o, rf_we_o, ready_o, timeout_o, rf_wdata_o} !== {4'b0010, 32'h0}) begin
                nerr++;
                $display("FAIL reset_late_valid cycle %0d: en/we/rdy/to=%b%b%b%b wdata=%h, want 0010 0", c, ppu_en_o, rf_we_o, ready_o, timeout_o, rf_wdata_o);
            end
        end
    endtask

    initial begin
        test_reset();
        test_op("basic", 3, PPU_ADD, 32'h40000000, 32'h40000000, 32'h48000000, 5'd5);
        test_op("rd_zero", 3, PPU_ADD, 32'h40000000, 32'h40000000, 32'h48000000, 5'd0);
        test_op("timeout", TO + 5, PPU_DIV, 32'h7FFFFFFF, 32'h00000001, 32'hFFFFFFFF, 5'd21);
        test_op("valid_vs_timeout", TO, PPU_MUL, 32'h3C000000, 32'h44000000, 32'h4C000000, 5'd30);
        test_idle_valid();
        test_flush_busy();
        test_flush_kinds();
        test_back_to_back();
        test_random();
        test_reset_busy();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
